// File: rtl/mano_instr_sequencer_if.sv
// rtl/mano_instr_sequencer_if.sv - IR/status inputs and strobe outputs between sequencer and datapath
interface mano_instr_sequencer_if;
  logic [15:0] ir;
  logic        ac_zero;
  logic        ac_sign;
  logic        e_flag;
  logic        dr_zero;
  logic        start;
  logic [2:0]  t;
  logic        halted;
  logic [2:0]  bus_sel;
  logic        ar_ld;
  logic        ar_inc;
  logic        pc_ld;
  logic        pc_inc;
  logic        dr_ld;
  logic        dr_inc;
  logic        ir_ld;
  logic        mem_wr;
  logic [3:0]  ac_op;
  logic        e_clr;
  logic        e_cmp;

  modport master (
    input  ir, ac_zero, ac_sign, e_flag, dr_zero, start,
    output t, halted, bus_sel, ar_ld, ar_inc, pc_ld, pc_inc,
           dr_ld, dr_inc, ir_ld, mem_wr, ac_op, e_clr, e_cmp
  );

  modport slave (
    output ir, ac_zero, ac_sign, e_flag, dr_zero, start,
    input  t, halted, bus_sel, ar_ld, ar_inc, pc_ld, pc_inc,
           dr_ld, dr_inc, ir_ld, mem_wr, ac_op, e_clr, e_cmp
  );
endinterface

// File: rtl/mano_instr_sequencer.sv
// rtl/mano_instr_sequencer.sv - T0..T6 instruction-cycle sequencer with HLT/restart
module mano_instr_sequencer (
  input  logic                        clk,
  input  logic                        reset,
  mano_instr_sequencer_if.master      seq
);
  typedef enum logic [2:0] {
    S_T0 = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3,
    S_T4 = 3'd4, S_T5 = 3'd5, S_T6 = 3'd6
  } step_t;

  localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7;

  step_t      sc, sc_next;
  logic       halted_q, halted_next;
  logic [2:0] opcode;
  logic       ind;
  logic       skip;

  assign opcode = seq.ir[14:12];
  assign ind    = seq.ir[15];
  assign skip   = (seq.ir[4] & ~seq.ac_sign) | (seq.ir[3] & seq.ac_sign) |
                  (seq.ir[2] & seq.ac_zero)  | (seq.ir[1] & ~seq.e_flag);

  always_ff @(posedge clk) begin
    if (reset) begin
      sc       <= S_T0;
      halted_q <= 1'b0;
    end else begin
      sc       <= sc_next;
      halted_q <= halted_next;
    end
  end

  // Reset and halt both force every strobe low; only the registered step is decoded otherwise.
  always_comb begin
    sc_next      = S_T0;
    halted_next  = halted_q;
    seq.t        = reset ? 3'd0 : sc;
    seq.halted   = halted_q & ~reset;
    seq.bus_sel  = 3'd0;
    seq.ar_ld    = 1'b0;
    seq.ar_inc   = 1'b0;
    seq.pc_ld    = 1'b0;
    seq.pc_inc   = 1'b0;
    seq.dr_ld    = 1'b0;
    seq.dr_inc   = 1'b0;
    seq.ir_ld    = 1'b0;
    seq.mem_wr   = 1'b0;
    seq.ac_op    = 4'd0;
    seq.e_clr    = 1'b0;
    seq.e_cmp    = 1'b0;
    if (reset) begin
      halted_next = 1'b0;
    end else if (halted_q) begin
      if (seq.start) halted_next = 1'b0;
    end else begin
      case (sc)
        S_T0: begin
          seq.bus_sel = 3'd2; seq.ar_ld = 1'b1; sc_next = S_T1;
        end
        S_T1: begin
          seq.bus_sel = 3'd7; seq.ir_ld = 1'b1; seq.pc_inc = 1'b1; sc_next = S_T2;
        end
        S_T2: begin
          seq.bus_sel = 3'd5; seq.ar_ld = 1'b1; sc_next = S_T3;
        end
        S_T3: begin
          if (opcode != OP_REG) begin
            if (ind) begin
              seq.bus_sel = 3'd7; seq.ar_ld = 1'b1;
            end
            sc_next = S_T4;
          end else if (!ind) begin
            if      (seq.ir[11]) seq.ac_op = 4'd4;
            else if (seq.ir[9])  seq.ac_op = 4'd5;
            else if (seq.ir[7])  seq.ac_op = 4'd6;
            else if (seq.ir[6])  seq.ac_op = 4'd7;
            else if (seq.ir[5])  seq.ac_op = 4'd8;
            seq.e_clr  = seq.ir[10];
            seq.e_cmp  = seq.ir[8];
            seq.pc_inc = skip;
            if (seq.ir[0]) halted_next = 1'b1;
          end
        end
        S_T4: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              seq.bus_sel = 3'd7; seq.dr_ld = 1'b1; sc_next = S_T5;
            end
            OP_STA: begin
              seq.bus_sel = 3'd4; seq.mem_wr = 1'b1;
            end
            OP_BUN: begin
              seq.bus_sel = 3'd1; seq.pc_ld = 1'b1;
            end
            OP_BSA: begin
              seq.bus_sel = 3'd2; seq.mem_wr = 1'b1; seq.ar_inc = 1'b1; sc_next = S_T5;
            end
            default: ;
          endcase
        end
        S_T5: begin
          case (opcode)
            OP_AND: seq.ac_op = 4'd1;
            OP_ADD: seq.ac_op = 4'd2;
            OP_LDA: seq.ac_op = 4'd3;
            OP_BSA: begin
              seq.bus_sel = 3'd1; seq.pc_ld = 1'b1;
            end
            OP_ISZ: begin
              seq.dr_inc = 1'b1; sc_next = S_T6;
            end
            default: ;
          endcase
        end
        S_T6: begin
          if (opcode == OP_ISZ) begin
            seq.bus_sel = 3'd3; seq.mem_wr = 1'b1; seq.pc_inc = seq.dr_zero;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mano_instr_sequencer.sv
// tb/tb_mano_instr_sequencer.sv - directed self-checking bench for mano_instr_sequencer
module tb_mano_instr_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  mano_instr_sequencer_if sq ();

  mano_instr_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .seq   (sq.master)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] AR_LD  = 8'b1000_0000, AR_INC = 8'b0100_0000;
  localparam logic [7:0] PC_LD  = 8'b0010_0000, PC_INC = 8'b0001_0000;
  localparam logic [7:0] DR_LD  = 8'b0000_1000, DR_INC = 8'b0000_0100;
  localparam logic [7:0] IR_LD  = 8'b0000_0010, MEM_WR = 8'b0000_0001;

  function automatic logic [16:0] ex(input logic [2:0] b, input logic [7:0] s,
                                     input logic [3:0] op, input logic [1:0] e);
    return {b, s, op, e};
  endfunction

  function automatic logic [16:0] obs();
    return {sq.bus_sel, sq.ar_ld, sq.ar_inc, sq.pc_ld, sq.pc_inc, sq.dr_ld, sq.dr_inc,
            sq.ir_ld, sq.mem_wr, sq.ac_op, sq.e_clr, sq.e_cmp};
  endfunction

  logic [16:0] e_t0, e_t1, e_t2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sq.ir = 16'h7800; sq.ac_zero = 0; sq.ac_sign = 0; sq.e_flag = 0; sq.dr_zero = 0; sq.start = 0;
    tick(); tick();
    total++; if (sq.t !== 3'd0) begin bad++; $display("FAIL reset_t got=%0d want=0", sq.t); end
    total++; if (sq.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", sq.halted); end
    total++; if (obs() !== 17'd0) begin bad++; $display("FAIL reset_strobes got=%h want=0", obs()); end
    reset = 1'b0;
    #1;
    total++; if (sq.t !== 3'd0 || obs() !== e_t0) begin
      bad++; $display("FAIL post_reset_t0 got t=%0d sig=%h want t=0 sig=%h", sq.t, obs(), e_t0);
    end
  endtask

  task automatic test_cla();
    logic [16:0] e [0:3];
    e[0] = e_t0; e[1] = e_t1; e[2] = e_t2; e[3] = ex(0, 0, 4'd4, 0);
    sq.ir = 16'h7800;
    for (int i = 0; i < 4; i++) begin
      total++; if (sq.t !== i[2:0] || obs() !== e[i]) begin
        bad++; $display("FAIL cla step %0d got t=%0d sig=%h want sig=%h", i, sq.t, obs(), e[i]);
      end
      tick();
    end
    total++; if (sq.t !== 3'd0) begin bad++; $display("FAIL cla_wrap got t=%0d want=0", sq.t); end
  endtask

  task automatic test_add_indirect();
    logic [16:0] e [0:5];
    e[0] = e_t0; e[1] = e_t1; e[2] = e_t2;
    e[3] = ex(7, AR_LD, 0, 0); e[4] = ex(7, DR_LD, 0, 0); e[5] = ex(0, 0, 4'd2, 0);
    sq.ir = 16'h9123;
    for (int i = 0; i < 6; i++) begin
      total++; if (sq.t !== i[2:0] || obs() !== e[i]) begin
        bad++; $display("FAIL add_ind step %0d got t=%0d sig=%h want sig=%h", i, sq.t, obs(), e[i]);
      end
      tick();
    end
    total++; if (sq.t !== 3'd0) begin bad++; $display("FAIL add_ind_wrap got t=%0d want=0", sq.t); end
  endtask

  task automatic test_isz();
    logic [16:0] e [0:6];
    for (int k = 0; k < 2; k++) begin
      sq.ir = 16'h6100;
      sq.dr_zero = (k == 0);
      e[0] = e_t0; e[1] = e_t1; e[2] = e_t2; e[3] = 17'd0;
      e[4] = ex(7, DR_LD, 0, 0); e[5] = ex(0, DR_INC, 0, 0);
      e[6] = ex(3, MEM_WR | ((k == 0) ? PC_INC : 8'd0), 0, 0);
      for (int i = 0; i < 7; i++) begin
        total++; if (sq.t !== i[2:0] || obs() !== e[i]) begin
          bad++; $display("FAIL isz dz=%0d step %0d got t=%0d sig=%h want sig=%h",
                          sq.dr_zero, i, sq.t, obs(), e[i]);
        end
        tick();
      end
      total++; if (sq.t !== 3'd0) begin bad++; $display("FAIL isz_wrap got t=%0d want=0", sq.t); end
    end
    sq.dr_zero = 1'b0;
  endtask

  task automatic test_regref();
    logic [15:0] v_ir  [0:9];
    logic [2:0]  v_flg [0:9];
    logic [16:0] v_e3  [0:9];
    v_ir[0] = 16'h7004; v_flg[0] = 3'b100; v_e3[0] = ex(0, PC_INC, 0, 0);
    v_ir[1] = 16'h7004; v_flg[1] = 3'b001; v_e3[1] = 17'd0;
    v_ir[2] = 16'h7A20; v_flg[2] = 3'b001; v_e3[2] = ex(0, 0, 4'd4, 0);
    v_ir[3] = 16'h7500; v_flg[3] = 3'b001; v_e3[3] = ex(0, 0, 0, 2'b11);
    v_ir[4] = 16'h7010; v_flg[4] = 3'b001; v_e3[4] = ex(0, PC_INC, 0, 0);
    v_ir[5] = 16'h7010; v_flg[5] = 3'b011; v_e3[5] = 17'd0;
    v_ir[6] = 16'h7008; v_flg[6] = 3'b011; v_e3[6] = ex(0, PC_INC, 0, 0);
    v_ir[7] = 16'h7002; v_flg[7] = 3'b000; v_e3[7] = ex(0, PC_INC, 0, 0);
    v_ir[8] = 16'h7280; v_flg[8] = 3'b001; v_e3[8] = ex(0, 0, 4'd5, 0);
    v_ir[9] = 16'h70C0; v_flg[9] = 3'b001; v_e3[9] = ex(0, 0, 4'd6, 0);
    for (int k = 0; k < 10; k++) begin
      sq.ir = v_ir[k];
      {sq.ac_zero, sq.ac_sign, sq.e_flag} = v_flg[k];
      tick(); tick(); tick();
      total++; if (sq.t !== 3'd3 || obs() !== v_e3[k]) begin
        bad++; $display("FAIL regref ir=%h got t=%0d sig=%h want sig=%h", v_ir[k], sq.t, obs(), v_e3[k]);
      end
      tick();
      total++; if (sq.t !== 3'd0) begin bad++; $display("FAIL regref_wrap ir=%h got t=%0d", v_ir[k], sq.t); end
    end
    {sq.ac_zero, sq.ac_sign, sq.e_flag} = 3'b000;
  endtask

  task automatic test_halt();
    sq.ir = 16'h7001;
    tick(); tick(); tick();
    total++; if (sq.t !== 3'd3 || obs() !== 17'd0 || sq.halted !== 1'b0) begin
      bad++; $display("FAIL hlt_t3 got t=%0d sig=%h halted=%b want t=3 sig=0 halted=0", sq.t, obs(), sq.halted);
    end
    sq.start = 1'b1;
    tick();
    sq.start = 1'b0;
    total++; if (sq.halted !== 1'b1) begin bad++; $display("FAIL hlt_enter got halted=%b want=1", sq.halted); end
    for (int i = 0; i < 10; i++) begin
      total++; if (sq.t !== 3'd0 || obs() !== 17'd0 || sq.halted !== 1'b1) begin
        bad++; $display("FAIL hlt_hold cyc %0d got t=%0d sig=%h halted=%b", i, sq.t, obs(), sq.halted);
      end
      tick();
    end
    sq.ir = 16'h7800;
    sq.start = 1'b1;
    #1;
    total++; if (obs() !== 17'd0) begin bad++; $display("FAIL hlt_start_cycle got sig=%h want=0", obs()); end
    tick();
    sq.start = 1'b0;
    total++; if (sq.halted !== 1'b0 || sq.t !== 3'd0 || obs() !== e_t0) begin
      bad++; $display("FAIL restart got halted=%b t=%0d sig=%h want sig=%h", sq.halted, sq.t, obs(), e_t0);
    end
  endtask

  task automatic test_bsa_reset();
    logic [16:0] e [0:5];
    e[0] = e_t0; e[1] = e_t1; e[2] = e_t2; e[3] = 17'd0;
    e[4] = ex(2, MEM_WR | AR_INC, 0, 0); e[5] = ex(1, PC_LD, 0, 0);
    sq.ir = 16'h5040;
    repeat (5) tick();
    total++; if (sq.t !== 3'd5 || obs() !== e[5]) begin
      bad++; $display("FAIL bsa_pre_t5 got t=%0d sig=%h want sig=%h", sq.t, obs(), e[5]);
    end
    reset = 1'b1;
    #1;
    total++; if (obs() !== 17'd0 || sq.t !== 3'd0) begin
      bad++; $display("FAIL bsa_reset_forced got t=%0d sig=%h want 0", sq.t, obs());
    end
    tick();
    reset = 1'b0;
    #1;
    total++; if (sq.t !== 3'd0 || sq.pc_ld !== 1'b0 || sq.halted !== 1'b0 || obs() !== e_t0) begin
      bad++; $display("FAIL bsa_abort got t=%0d pc_ld=%b halted=%b sig=%h", sq.t, sq.pc_ld, sq.halted, obs());
    end
    for (int i = 0; i < 6; i++) begin
      total++; if (sq.t !== i[2:0] || obs() !== e[i]) begin
        bad++; $display("FAIL bsa step %0d got t=%0d sig=%h want sig=%h", i, sq.t, obs(), e[i]);
      end
      tick();
    end
    total++; if (sq.t !== 3'd0) begin bad++; $display("FAIL bsa_wrap got t=%0d want=0", sq.t); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e [0:5];
    logic [15:0] instr [0:3];
    int          len [0:3];
    instr[0] = 16'h3000; len[0] = 5;
    instr[1] = 16'h4000; len[1] = 5;
    instr[2] = 16'hF000; len[2] = 4;
    instr[3] = 16'h2000; len[3] = 6;
    for (int k = 0; k < 4; k++) begin
      e[0] = e_t0; e[1] = e_t1; e[2] = e_t2; e[3] = 17'd0; e[5] = 17'd0;
      case (k)
        0: e[4] = ex(4, MEM_WR, 0, 0);
        1: e[4] = ex(1, PC_LD, 0, 0);
        2: e[4] = 17'd0;
        default: begin e[4] = ex(7, DR_LD, 0, 0); e[5] = ex(0, 0, 4'd3, 0); end
      endcase
      sq.ir = instr[k];
      for (int i = 0; i < len[k]; i++) begin
        total++; if (sq.t !== i[2:0] || obs() !== e[i]) begin
          bad++; $display("FAIL b2b ir=%h step %0d got t=%0d sig=%h want sig=%h", instr[k], i, sq.t, obs(), e[i]);
        end
        tick();
      end
      total++; if (sq.t !== 3'd0) begin bad++; $display("FAIL b2b_wrap ir=%h got t=%0d", instr[k], sq.t); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    e_t0 = ex(2, AR_LD, 0, 0);
    e_t1 = ex(7, IR_LD | PC_INC, 0, 0);
    e_t2 = ex(5, AR_LD, 0, 0);
    test_reset();
    test_cla();
    test_add_indirect();
    test_isz();
    test_regref();
    test_halt();
    test_bsa_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
